// File: rtl/alu_trace_recorder.sv
// alu_trace_recorder: captures ALUdec/ALU transactions as
// 107-bit test-vector records and streams them out as 32-bit words.
//
// Record: {opcode, funct, add_rshift_type, A, B, Out}, zero-padded
// to 128 bits, buffered DEPTH deep, emitted MSB word first.
//
// Ports:
//   Clock, Reset          clock, async active-high reset
//   trace_en              capture enable
//   cap_valid             transaction present on cap_* inputs
//   cap_opcode/funct/     ALUdec inputs
//   cap_add_rshift_type
//   cap_A/cap_B/cap_out   ALU operands and result
//   cap_full              FIFO holds DEPTH records
//   overflow              sticky, a capture was dropped
//   count                 records buffered
//   out_valid/out_ready   word stream handshake
//   out_data/out_last     current word, last word of record
//   drop_count            dropped captures, saturating
//                         (only with ALU_TRACE_DROP_COUNT_EN)
//
// Optional feature macro: ALU_TRACE_DROP_COUNT_EN
module alu_trace_recorder #(
  parameter int DEPTH = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       trace_en,
  input  logic                       cap_valid,
  input  logic [6:0]                 cap_opcode,
  input  logic [2:0]                 cap_funct,
  input  logic                       cap_add_rshift_type,
  input  logic [31:0]                cap_A,
  input  logic [31:0]                cap_B,
  input  logic [31:0]                cap_out,
  output logic                       cap_full,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic                       out_last
`ifdef ALU_TRACE_DROP_COUNT_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = 107;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [RW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    beat_q, beat_d;
  logic          ovf_q, ovf_d;

  logic          capture;
  logic          full;
  logic          push;
  logic          drop;
  logic          xfer;
  logic          pop;
  logic [RW-1:0] rec_in;
  logic [127:0]  head;
  logic [31:0]   word;

  assign rec_in = {cap_opcode, cap_funct,
                   cap_add_rshift_type,
                   cap_A, cap_B, cap_out};

  // Fullness comes from the registered count only, so a
  // pop in the same cycle never frees room for a push.
  assign full    = (count_q == FULL_C);
  assign capture = cap_valid && trace_en;
  assign push    = capture && !full;
  assign drop    = capture && full;

  assign out_valid = (count_q != '0);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (beat_q == 2'd3);

  assign head = {21'b0, mem_q[rd_ptr_q]};

  always_comb begin
    word = '0;
    unique case (beat_q)
      2'd0: word = head[127:96];
      2'd1: word = head[95:64];
      2'd2: word = head[63:32];
      2'd3: word = head[31:0];
      default: word = '0;
    endcase
  end

  assign out_data = out_valid ? word : '0;
  assign out_last = out_valid && (beat_q == 2'd3);
  assign cap_full = full;
  assign overflow = ovf_q;
  assign count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (xfer) beat_d = beat_q + 2'd1;
    if (drop) ovf_d = 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: out_data is masked while empty.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
  end

`ifdef ALU_TRACE_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule
